spi_master: RTL and testbench
=============================

# spi_master

Byte-oriented SPI master (mode 0, MSB first, active-low chip select) that drives the team's SPI slave from the AES-side controller. It generates sclk from the system clock, shifts one byte out on mosi while shifting one byte in from miso, and supports back-to-back multi-byte transactions with cs held low. It sits between the AES key/data sequencer and the external SPI pins.

## Interface
- CLK_DIV, 4: clk cycles per sclk half-period; legal range ≥ 4, covering the slave's 3-cycle input synchronisation.
- Ports:
  - clk  in  1  system clock.
  - reset  in  1  synchronous, active-high reset (clock clk).
  - start  in  1  request a byte transfer; accepted only when busy=0.
  - last  in  1  sampled with start; 1 = release cs after this byte.
  - data_in  in  8  byte to transmit; sampled on accepted start.
  - data_out  out  8  last received byte; updated when done pulses.
  - busy  out  1  high while a byte is shifting or cs is being released.
  - done  out  1  one-cycle pulse: byte complete, data_out valid.
  - sclk  out  1  serial clock, idle low.
  - mosi  out  1  master data out.
  - miso  in  1  slave data in; may be Z while cs=1.
  - cs  out  1  chip select, active low.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, FINISH.
- IDLE: cs=1, sclk=0, mosi=0, busy=0. If start=1, latch data_in into tx shift register and latch last. Set cs<=0 and mosi<=data_in[7], then go to SETUP.
- SETUP: sclk=0 for CLK_DIV cycles, then sclk<=1 and go to HIGH.
- HIGH: after CLK_DIV cycles, sclk<=0 and rx<={rx[6:0],miso}; miso is sampled at the end of the high phase. Increment bit_cnt (3-bit).
  - If bit_cnt was 7: data_out<=new rx value and done<=1. Go to FINISH if latched last=1, else HOLD.
  - Otherwise: shift tx left, mosi<=next bit, go to LOW.
- LOW: after CLK_DIV cycles, sclk<=1 and go to HIGH.
- HOLD: cs=0, sclk=0, busy=0, mosi holds its last value.
  - On start=1: latch data_in and last, mosi<=data_in[7], go to SETUP.
  - With no start: wait indefinitely.
- FINISH: cs stays low for CLK_DIV cycles, then cs<=1 and go to IDLE.
- start while busy=1 is ignored. data_in and last are don't-care except on the accepted start cycle.
- Half-period counter restarts at 0 on every state entry.

## Timing
- All outputs are registered.
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, data_out=8'h00, state IDLE, bit_cnt=0.
- Reset mid-transfer aborts on the next edge with the same values. The partial byte is discarded and there is no done pulse.
- With start accepted at edge T0:
  - cs falls and busy rises at T0+1.
  - First sclk rise at T0+1+CLK_DIV.
  - Eighth sclk fall and done pulse at T0+1+16·CLK_DIV (65 cycles at CLK_DIV=4).
- When last=1, cs rises and busy falls CLK_DIV cycles after done.
- When last=0, busy falls in the same cycle done rises. A start in that cycle or later is accepted.
- sclk period is 2·CLK_DIV cycles with 50% duty, except SETUP, which adds one half-period before the first rise.
- mosi changes only on sclk falling edges (or at the SETUP entry), so it is stable across each rising edge.

## Structure
- Shared package spi_pkg holds:
  - state encoding (3-bit localparams)
  - MIN_CLK_DIV=4
  - SPI_BITS=8
- One sub-module: spi_half_period_counter. It counts to CLK_DIV-1, asserts a one-cycle tick, and clears on a restart input.
- FSM, shift registers and outputs live in spi_master.

## Test plan
- Single byte, CLK_DIV=4, data_in=8'hA5, last=1, slave loaded with 8'h3C:
  - slave data_out=8'hA5 and master data_out=8'h3C.
  - done at start+65 cycles.
  - cs high 4 cycles later.
- Burst of 8'h01, 8'h80, 8'hFF (last=0, 0, 1), each start issued the cycle after done:
  - cs stays low throughout.
  - three done pulses.
  - slave receives the bytes in order.
- start asserted while busy (mid-byte):
  - ignored.
  - tx byte and sclk count unchanged; exactly 8 sclk rises per byte.
- reset asserted at bit 4:
  - next cycle cs=1, sclk=0, mosi=0, busy=0, data_out=8'h00, no done.
  - a new transfer of 8'h5A then completes correctly.
- CLK_DIV=6 with mosi checked at every sclk rise:
  - mosi is stable at least 6 cycles before each rise.
  - sclk high and low phases are each exactly 6 cycles.
- miso driven Z while idle, then a transfer with the slave returning 8'h00:
  - data_out=8'h00 with no X.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: state encoding and transfer geometry.
package spi_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_HIGH   = 3'd2;
   localparam logic [2:0] ST_LOW    = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;

   localparam int MIN_CLK_DIV = 4;
   localparam int SPI_BITS    = 8;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_SETUP  = ST_SETUP,
      S_HIGH   = ST_HIGH,
      S_LOW    = ST_LOW,
      S_HOLD   = ST_HOLD,
      S_FINISH = ST_FINISH
   } spi_state_e;

endpackage

// File: rtl/spi_half_period_counter.sv
// Counts clk cycles within one sclk half-period; ticks on the last cycle and
// restarts from zero whenever the master changes state.
module spi_half_period_counter
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
)
(
   input  logic clk,
   input  logic reset,
   input  logic restart_i,
   output logic tick_o
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (cnt_q == TERM) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0, MSB first, active-low chip select, with
// back-to-back bytes under one cs assertion.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       last,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       done,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs
);

   if (CLK_DIV < MIN_CLK_DIV) begin : g_bad_div
      $error("spi_master: CLK_DIV must be at least MIN_CLK_DIV");
   end

   localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

   spi_state_e state_q, state_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       last_q, last_d;
   logic       cs_q, cs_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] data_out_q, data_out_d;
   logic [7:0] rx_next_s;
   logic       tick_s;
   logic       restart_s;

   assign restart_s = (state_d != state_q);

   spi_half_period_counter #(.CLK_DIV(CLK_DIV)) u_half_cnt (
      .clk       (clk),
      .reset     (reset),
      .restart_i (restart_s),
      .tick_o    (tick_s)
   );

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bit_cnt_d  = bit_cnt_q;
      last_d     = last_q;
      cs_d       = cs_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      data_out_d = data_out_q;
      rx_next_s  = {rx_q[6:0], miso};

      case (state_q)
         S_IDLE: begin
            cs_d   = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               tx_d      = data_in;
               last_d    = last;
               bit_cnt_d = 3'd0;
               cs_d      = 1'b0;
               mosi_d    = data_in[7];
               busy_d    = 1'b1;
               state_d   = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (tick_s) begin
               sclk_d  = 1'b1;
               state_d = S_HIGH;
            end else begin
               state_d = S_SETUP;
            end
         end
         S_HIGH: begin
            if (tick_s) begin
               sclk_d    = 1'b0;
               rx_d      = rx_next_s;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  data_out_d = rx_next_s;
                  done_d     = 1'b1;
                  if (last_q) begin
                     state_d = S_FINISH;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = S_HOLD;
                  end
               end else begin
                  // mosi moves only on the falling edge so it is settled by the next rise
                  tx_d    = {tx_q[6:0], 1'b0};
                  mosi_d  = tx_q[6];
                  state_d = S_LOW;
               end
            end else begin
               state_d = S_HIGH;
            end
         end
         S_LOW: begin
            if (tick_s) begin
               sclk_d  = 1'b1;
               state_d = S_HIGH;
            end else begin
               state_d = S_LOW;
            end
         end
         S_HOLD: begin
            if (start) begin
               tx_d      = data_in;
               last_d    = last;
               bit_cnt_d = 3'd0;
               mosi_d    = data_in[7];
               busy_d    = 1'b1;
               state_d   = S_SETUP;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_FINISH: begin
            if (tick_s) begin
               cs_d    = 1'b1;
               busy_d  = 1'b0;
               mosi_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_FINISH;
            end
         end
         default: begin
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tx_q       <= 8'h00;
         rx_q       <= 8'h00;
         bit_cnt_q  <= 3'd0;
         last_q     <= 1'b0;
         cs_q       <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         data_out_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         bit_cnt_q  <= bit_cnt_d;
         last_q     <= last_d;
         cs_q       <= cs_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign cs       = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a mode-0 slave model at CLK_DIV=4 and a
// loopback instance at CLK_DIV=6 for sclk/mosi timing.
module tb_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start, last;
   logic [7:0] data_in;
   wire  [7:0] data_out;
   wire        busy, done, sclk, mosi, cs;
   wire        miso;
   logic       miso_bit = 1'b0;

   assign miso = cs ? 1'bz : miso_bit;

   spi_master #(.CLK_DIV(4)) dut (
      .clk(clk), .reset(reset), .start(start), .last(last), .data_in(data_in),
      .data_out(data_out), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
      .miso(miso), .cs(cs)
   );

   logic       start6, last6;
   logic [7:0] data_in6;
   wire  [7:0] data_out6;
   wire        busy6, done6, sclk6, mosi6, cs6;

   spi_master #(.CLK_DIV(6)) dut6 (
      .clk(clk), .reset(reset), .start(start6), .last(last6), .data_in(data_in6),
      .data_out(data_out6), .busy(busy6), .done(done6), .sclk(sclk6), .mosi(mosi6),
      .miso(mosi6), .cs(cs6)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int rises = 0;

   logic [7:0] exp_q[$];
   logic [7:0] slv_exp_q[$];
   logic [7:0] slv_got_q[$];
   logic [7:0] slv_tx_q[$];
   logic [7:0] exp6_q[$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %0h, required %0h", name, act, req);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge sclk) rises <= rises + 1;

   // Mode-0 slave: loads its reply at the first rise of each byte, samples mosi on rises.
   logic       cs_p = 1'b1, sclk_p = 1'b0;
   logic [7:0] s_sh = 8'h00, s_rx = 8'h00;
   int         s_cnt = 0;
   always @(posedge clk) begin
      if (cs_p && !cs) begin
         s_cnt = 0;
      end else if (!cs) begin
         if (!sclk_p && sclk) begin
            if (s_cnt == 0) s_sh = (slv_tx_q.size() > 0) ? slv_tx_q.pop_front() : 8'h00;
            s_rx = {s_rx[6:0], mosi};
            s_cnt++;
            if (s_cnt == 8) begin
               slv_got_q.push_back(s_rx);
               s_cnt = 0;
            end
         end else if (sclk_p && !sclk) begin
            s_sh = {s_sh[6:0], 1'b0};
         end
      end
      cs_p = cs;
      sclk_p = sclk;
      miso_bit <= s_sh[7];
   end

   // Monitor: pops expectations whenever a DUT presents a result, and times dut6 edges.
   logic sclk6_p = 1'b0, mosi6_p = 1'b0;
   int   mosi6_chg = 0, rise6 = 0, fall6 = -1;
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) chk("unexpected done", 32'd1, 32'd0);
         else begin
            chk("master rx byte", data_out, exp_q.pop_front());
            chk("master rx known", $isunknown(data_out), 32'd0);
         end
      end
      while (slv_got_q.size() > 0) begin
         if (slv_exp_q.size() == 0) chk("slave extra byte", slv_got_q.pop_front(), 32'hFFFF);
         else chk("slave rx byte", slv_got_q.pop_front(), slv_exp_q.pop_front());
      end
      if (done6) begin
         if (exp6_q.size() == 0) chk("unexpected done6", 32'd1, 32'd0);
         else chk("div6 loopback byte", data_out6, exp6_q.pop_front());
      end
      if (mosi6 !== mosi6_p) mosi6_chg = cyc;
      if (sclk6 && !sclk6_p) begin
         chk("div6 mosi stable before rise", (cyc - mosi6_chg) >= 6, 32'd1);
         if (fall6 >= 0) chk("div6 low phase", cyc - fall6, 32'd6);
         rise6 = cyc;
      end
      if (!sclk6 && sclk6_p) begin
         chk("div6 high phase", cyc - rise6, 32'd6);
         fall6 = cyc;
      end
      if (cs6) fall6 = -1;
      sclk6_p = sclk6;
      mosi6_p = mosi6;
   end

   task automatic issue(input logic [7:0] d, input logic l, input logic [7:0] slave_byte, output int acc);
      exp_q.push_back(slave_byte);
      slv_exp_q.push_back(d);
      slv_tx_q.push_back(slave_byte);
      start = 1'b1;
      data_in = d;
      last = l;
      @(negedge clk);
      start = 1'b0;
      data_in = ~d;
      last = ~l;
      acc = cyc;
   endtask

   task automatic wait_done(input int budget, output int dcyc, inout int cs_hi);
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cs) cs_hi++;
         if (done) begin
            dcyc = cyc;
            break;
         end
      end
      if (dcyc < 0) chk("done timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int acc, dc, cs_hi, base, ndone;
      reset = 1'b1;
      start = 1'b0; last = 1'b0; data_in = 8'h00;
      start6 = 1'b0; last6 = 1'b0; data_in6 = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset cs", cs, 32'd1);
      chk("reset sclk", sclk, 32'd0);
      chk("reset mosi", mosi, 32'd0);
      chk("reset busy", busy, 32'd0);
      chk("reset done", done, 32'd0);
      chk("reset data_out", data_out, 32'h00);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // single byte A5 out, 3C back
      cs_hi = 0;
      issue(8'hA5, 1'b1, 8'h3C, acc);
      chk("cs falls after accept", cs, 32'd0);
      chk("busy rises after accept", busy, 32'd1);
      wait_done(200, dc, cs_hi);
      chk("done latency", dc - acc, 32'd64);
      repeat (3) @(negedge clk);
      chk("cs held through finish", cs, 32'd0);
      @(negedge clk);
      chk("cs released 4 after done", cs, 32'd1);
      chk("busy low after release", busy, 32'd0);
      repeat (3) @(negedge clk);

      // burst 01, 80, FF under one cs
      cs_hi = 0;
      ndone = 0;
      issue(8'h01, 1'b0, 8'h11, acc);
      wait_done(200, dc, cs_hi);
      if (dc >= 0) ndone++;
      chk("busy low with done (last=0)", busy, 32'd0);
      @(negedge clk);
      issue(8'h80, 1'b0, 8'h22, acc);
      wait_done(200, dc, cs_hi);
      if (dc >= 0) ndone++;
      @(negedge clk);
      issue(8'hFF, 1'b1, 8'h33, acc);
      wait_done(200, dc, cs_hi);
      if (dc >= 0) ndone++;
      chk("burst cs high cycles", cs_hi, 32'd0);
      chk("burst done pulses", ndone, 32'd3);
      repeat (6) @(negedge clk);

      // start while busy is ignored
      cs_hi = 0;
      base = rises;
      issue(8'h96, 1'b1, 8'h69, acc);
      repeat (20) @(negedge clk);
      start = 1'b1; data_in = 8'h00; last = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done(200, dc, cs_hi);
      chk("sclk rises per byte", rises - base, 32'd8);
      repeat (6) @(negedge clk);
      chk("no queued transfer cs", cs, 32'd1);
      chk("no queued transfer busy", busy, 32'd0);

      // reset at bit 4
      base = rises;
      issue(8'hE7, 1'b1, 8'h5B, acc);
      for (int i = 0; i < 100 && (rises - base) < 4; i++) @(negedge clk);
      chk("reached bit 4", (rises - base) >= 4, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort cs", cs, 32'd1);
      chk("abort sclk", sclk, 32'd0);
      chk("abort mosi", mosi, 32'd0);
      chk("abort busy", busy, 32'd0);
      chk("abort data_out", data_out, 32'h00);
      chk("abort done", done, 32'd0);
      reset = 1'b0;
      exp_q.delete();
      slv_exp_q.delete();
      slv_tx_q.delete();
      repeat (3) @(negedge clk);
      cs_hi = 0;
      issue(8'h5A, 1'b1, 8'hC3, acc);
      wait_done(200, dc, cs_hi);
      chk("post-reset done latency", dc - acc, 32'd64);
      repeat (6) @(negedge clk);

      // miso floating while idle, slave returns 00
      repeat (10) @(negedge clk);
      cs_hi = 0;
      issue(8'hFF, 1'b1, 8'h00, acc);
      wait_done(200, dc, cs_hi);
      repeat (6) @(negedge clk);

      // CLK_DIV=6 loopback
      exp6_q.push_back(8'hC3);
      start6 = 1'b1; data_in6 = 8'hC3; last6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0; data_in6 = 8'h00; last6 = 1'b0;
      acc = cyc;
      dc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done6) begin
            dc = cyc;
            break;
         end
      end
      chk("div6 done latency", dc - acc, 32'd96);
      repeat (10) @(negedge clk);
      chk("div6 cs released", cs6, 32'd1);

      chk("pending expectations", exp_q.size() + slv_exp_q.size() + exp6_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, n_err %0d", n_err);
      $fatal(1);
   end

endmodule
